axis_daq_trig: RTL
==================

# axis_daq_trig

Parametrised multi-channel DAQ capture engine with a pre-trigger ring buffer. It accepts packed ADC sample frames on an AXI-Stream slave and writes them continuously into a circular BRAM region. A trigger can come from a signed threshold crossing on a selectable channel, an external pin, or software. After the trigger it captures a programmable number of post-trigger frames, then reports done together with the trigger address. It sits between the ADC stream and the ARM-readable BRAM, in the same place as the existing single-channel DAQ.

## Interface
- NUM_CH, 2: channels packed in each frame (1..16)
- SAMPLE_W, 16: signed sample width per channel
- AXIS_TDATA_WIDTH, 32: must be ≥ NUM_CH*SAMPLE_W
- BRAM_ADDR_WIDTH, 14: ring depth is 2^BRAM_ADDR_WIDTH frames
- BRAM_DATA_WIDTH, 32: must be ≥ NUM_CH*SAMPLE_W; upper bits written 0

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- trig_ext_i  in  1  external trigger level, already synchronous to aclk
- daq_control  in  32  [0] enable, [1] edge (0 rising, 1 falling), [2] sw trigger, [3] use ext trigger, [7:4] trigger channel, [31:16] signed threshold
- daq_pretrig  in  BRAM_ADDR_WIDTH  pre-trigger frames
- daq_length  in  BRAM_ADDR_WIDTH  total frames per record; 0 means 2^BRAM_ADDR_WIDTH
- daq_status  out  32  [0] done, [1] triggered, [2] busy, [31:3] 0
- daq_trig_addr  out  BRAM_ADDR_WIDTH  BRAM address of the trigger frame
- s_axis_tready  out  1  constant 1
- s_axis_tdata  in  AXIS_TDATA_WIDTH  channel k at [k*SAMPLE_W +: SAMPLE_W]
- s_axis_tvalid  in  1  frame valid
- bram_porta_clk  out  1  = aclk
- bram_porta_addr  out  BRAM_ADDR_WIDTH  write address
- bram_porta_wrdata  out  BRAM_DATA_WIDTH  frame data
- bram_porta_we  out  1  write strobe

## Operation
- **Reset values:** state IDLE; all status bits 0; daq_trig_addr 0; bram_porta_we 0; addr 0; wrdata 0.
- **Latched configuration.** In IDLE, when enable=1:
  - latch threshold, edge, channel, source, pretrig and length;
  - clamp pretrig to length-1;
  - reset the write address to 0 and go to PRETRIG.
- **Trigger channel.** A channel index ≥ NUM_CH selects channel 0.
- **Writing.** In PRETRIG, ARMED and POST, every accepted frame (tvalid=1) is written to the current address. The address then increments modulo 2^BRAM_ADDR_WIDTH, wrapping freely.
- **PRETRIG.** Counts latched-pretrig frames, then goes to ARMED. With pretrig=0 it goes to ARMED on the next cycle. Triggers are ignored in PRETRIG.
- **ARMED.** Evaluates the trigger on each accepted frame:
  - rising: prev < thr and cur ≥ thr;
  - falling: prev ≥ thr and cur < thr;
  - ext: trig_ext_i 0→1 edge;
  - sw: daq_control[2]=1 (level); it overrides the other sources;
  - prev is the previous accepted frame's sample on the selected channel. The first frame accepted in ARMED cannot produce a threshold trigger.
- **On trigger:**
  - the trigger frame is written;
  - daq_trig_addr latches that frame's address;
  - triggered=1;
  - the trigger frame counts as post frame 1.
- **POST.** Writes until (length − pretrig) post frames are written, then goes to DONE.
- **DONE.** done=1 and writes stop. When enable=0, go to IDLE; done and triggered clear.
- **Busy.** busy=1 in PRETRIG, ARMED and POST.
- **Abort.** enable=0 in PRETRIG, ARMED or POST goes to IDLE on the next cycle. done stays 0; any in-flight write completes.
- **Reset mid-capture.** Returns all state and outputs to reset values.
- **Readout.** The record starts at (daq_trig_addr − pretrig) mod 2^BRAM_ADDR_WIDTH.

## Timing
- Write latency: one registered stage. A frame accepted at cycle n gives we=1, addr and data at cycle n+1.
- Frame rate: one frame per cycle sustained; no stall ever.
- Trigger decision: combinational on the accepted frame, so the trigger frame itself is the first post frame.
- Status update: done asserts the cycle after the last post write is issued. triggered asserts together with the trigger frame's we.
- Gaps: tvalid gaps pause all counters; the FSM does not advance on invalid cycles, except the IDLE→PRETRIG and DONE→IDLE transitions.

## Structure
- Package axis_daq_pkg:
  - state enum IDLE / PRETRIG / ARMED / POST / DONE;
  - daq_control bit and field positions;
  - daq_status bit positions.
- Sub-module daq_trigger_detect:
  - channel mux, prev-sample register and edge compare;
  - ext-edge detect and source select;
  - outputs a one-cycle trig pulse qualified by tvalid.

## Test plan
- **Basic capture.** NUM_CH=2, pretrig=4, length=16, rising, thr=100, ch1 ramp 0,20,40,…. Trigger on the sample 100 frame; daq_trig_addr = its address; exactly 12 post frames written; done=1.
- **Falling, wrap-around.** BRAM_ADDR_WIDTH=4, pretrig=3, length=8; 20 frames held in ARMED before a falling crossing of thr=0. Address wraps; start = (trig_addr − 3) mod 16 holds the 3 frames before the trigger.
- **Ext and sw trigger.** Pulse trig_ext_i with the use-ext bit set → trigger on that frame. Set daq_control[2] → immediate trigger even with no threshold crossing.
- **Abort.** Drop enable in ARMED → IDLE next cycle, done=0, no further we. Assert aresetn=0 mid-POST → all outputs at reset values.
- **tvalid gaps and boundaries.** tvalid 50% random during a capture → total writes exactly = length. length=0 → 2^BRAM_ADDR_WIDTH frames. pretrig ≥ length → clamped to length−1.

Source files
------------

// File: rtl/axis_daq_pkg.sv
// Shared types and register field positions for the multi-channel DAQ capture engine.
// Bit positions here must match the ARM-side driver's view of daq_control/daq_status.
package axis_daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRETRIG = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } daq_state_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_EDGE    = 1;
    localparam int CTRL_SW      = 2;
    localparam int CTRL_EXT     = 3;
    localparam int CTRL_CH_LSB  = 4;
    localparam int CTRL_CH_W    = 4;
    localparam int CTRL_THR_LSB = 16;
    localparam int CTRL_THR_W   = 16;

    localparam int STAT_DONE = 0;
    localparam int STAT_TRIG = 1;
    localparam int STAT_BUSY = 2;

    typedef struct packed {
        logic signed [CTRL_THR_W-1:0] thr;
        logic [CTRL_CH_W-1:0]         ch;
        logic                         falling;
        logic                         use_ext;
    } daq_cfg_t;

endpackage

// File: rtl/daq_trigger_detect.sv
// Trigger source evaluation: threshold crossing on one channel, external edge or software.
// trig_o is combinational on the accepted frame so the trigger frame itself is post frame 1.
module daq_trigger_detect
    import axis_daq_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int SAMPLE_W         = 16,
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          armed_i,
    input  logic                          tvalid_i,
    input  logic [AXIS_TDATA_WIDTH-1:0]   tdata_i,
    input  logic [CTRL_CH_W-1:0]          ch_i,
    input  logic signed [CTRL_THR_W-1:0]  thr_i,
    input  logic                          falling_i,
    input  logic                          use_ext_i,
    input  logic                          sw_i,
    input  logic                          trig_ext_i,
    output logic                          trig_o
);
    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic                       prev_vld_q, prev_vld_d;
    logic                       ext_q;
    logic signed [31:0]         cur_x, prev_x, thr_x;
    logic                       above_cur, above_prev, thr_hit, ext_edge;

    // Out-of-range channel indices fall through to channel 0.
    always_comb begin
        cur_s = tdata_i[SAMPLE_W-1:0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (int'(ch_i) == k) cur_s = tdata_i[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        cur_x      = 32'(cur_s);
        prev_x     = 32'(prev_q);
        thr_x      = 32'(thr_i);
        above_cur  = (cur_x >= thr_x);
        above_prev = (prev_x >= thr_x);
        thr_hit    = prev_vld_q & (falling_i ? (above_prev & ~above_cur)
                                             : (~above_prev & above_cur));
        ext_edge   = trig_ext_i & ~ext_q;
        trig_o     = armed_i & tvalid_i & (sw_i | (use_ext_i ? ext_edge : thr_hit));
    end

    // History only counts frames seen while armed, so the first armed frame has no predecessor.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (!armed_i) begin
            prev_vld_d = 1'b0;
        end else if (tvalid_i) begin
            prev_d     = cur_s;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            ext_q      <= trig_ext_i;
        end
    end

endmodule

// File: rtl/axis_daq_trig.sv
// Multi-channel DAQ capture engine: streams frames into a BRAM ring, stops a programmable
// number of frames after a trigger and reports where the trigger frame landed.
//
//   state   | meaning
//   IDLE    | waiting for enable; configuration latched on the way out
//   PRETRIG | filling the guaranteed pre-trigger history, triggers ignored
//   ARMED   | writing frames and evaluating the trigger on each one
//   POST    | writing the remaining post-trigger frames
//   DONE    | record complete, writes stopped until enable drops
module axis_daq_trig
    import axis_daq_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int SAMPLE_W         = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 14,
    parameter int BRAM_DATA_WIDTH  = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         trig_ext_i,
    input  logic [31:0]                  daq_control,
    input  logic [BRAM_ADDR_WIDTH-1:0]   daq_pretrig,
    input  logic [BRAM_ADDR_WIDTH-1:0]   daq_length,
    output logic [31:0]                  daq_status,
    output logic [BRAM_ADDR_WIDTH-1:0]   daq_trig_addr,
    output logic                         s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         bram_porta_clk,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
    output logic                         bram_porta_we
);
    localparam int          AW      = BRAM_ADDR_WIDTH;
    localparam int          FRAME_W = NUM_CH * SAMPLE_W;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    daq_state_e                 state_q, state_d;
    daq_cfg_t                   cfg_q, cfg_d;
    logic [AW-1:0]              ptr_q, ptr_d;
    logic [AW-1:0]              trig_addr_q, trig_addr_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic [AW:0]                post_q, post_d;
    logic                       triggered_q, triggered_d;
    logic                       we_q, we_d;
    logic [BRAM_DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [BRAM_DATA_WIDTH-1:0] frame_data;
    logic [AW:0]                len_eff, pre_ext, pre_clamp;
    logic                       en, busy, accept, armed, trig;
    logic                       unused_ctrl;

    assign unused_ctrl    = ^daq_control[15:8];
    assign s_axis_tready  = 1'b1;
    assign bram_porta_clk = aclk;

    assign en     = daq_control[CTRL_EN];
    assign busy   = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign accept = en & busy & s_axis_tvalid;
    assign armed  = en & (state_q == ST_ARMED);

    // Length 0 encodes a full ring; pretrig must leave room for at least the trigger frame.
    always_comb begin
        len_eff   = (daq_length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, daq_length};
        pre_ext   = {1'b0, daq_pretrig};
        pre_clamp = (pre_ext >= len_eff) ? (len_eff - CNT_ONE) : pre_ext;
    end

    always_comb begin
        frame_data              = '0;
        frame_data[FRAME_W-1:0] = s_axis_tdata[FRAME_W-1:0];
    end

    daq_trigger_detect #(
        .NUM_CH           (NUM_CH),
        .SAMPLE_W         (SAMPLE_W),
        .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_trig (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .armed_i    (armed),
        .tvalid_i   (s_axis_tvalid),
        .tdata_i    (s_axis_tdata),
        .ch_i       (cfg_q.ch),
        .thr_i      (cfg_q.thr),
        .falling_i  (cfg_q.falling),
        .use_ext_i  (cfg_q.use_ext),
        .sw_i       (daq_control[CTRL_SW]),
        .trig_ext_i (trig_ext_i),
        .trig_o     (trig)
    );

    always_comb begin
        we_d     = accept;
        addr_d   = accept ? ptr_q : addr_q;
        wrdata_d = accept ? frame_data : wrdata_q;
        ptr_d    = accept ? (ptr_q + 1'b1) : ptr_q;
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        post_d      = post_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        if (!en) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d         = ST_PRETRIG;
                    cfg_d.thr       = daq_control[CTRL_THR_LSB +: CTRL_THR_W];
                    cfg_d.ch        = daq_control[CTRL_CH_LSB +: CTRL_CH_W];
                    cfg_d.falling   = daq_control[CTRL_EDGE];
                    cfg_d.use_ext   = daq_control[CTRL_EXT];
                    cnt_d           = pre_clamp;
                    post_d          = len_eff - pre_clamp;
                    triggered_d     = 1'b0;
                end
                ST_PRETRIG: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else if (s_axis_tvalid) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        trig_addr_d = ptr_q;
                        triggered_d = 1'b1;
                        cnt_d       = post_q - CNT_ONE;
                        state_d     = (post_q == CNT_ONE) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (s_axis_tvalid) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            post_q      <= '0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            ptr_q       <= (state_q == ST_IDLE) ? '0 : ptr_d;
            cnt_q       <= cnt_d;
            post_q      <= post_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
        end
    end

    always_comb begin
        daq_status            = '0;
        daq_status[STAT_DONE] = (state_q == ST_DONE);
        daq_status[STAT_TRIG] = triggered_q;
        daq_status[STAT_BUSY] = busy;
    end

    assign daq_trig_addr     = trig_addr_q;
    assign bram_porta_addr   = addr_q;
    assign bram_porta_wrdata = wrdata_q;
    assign bram_porta_we     = we_q;

endmodule
